amba3_apb_reg_slave: RTL

AMBA3_APB_REG_SLAVE -- requirements
Module: amba3_apb_reg_slave

---
 rtl/amba3_apb_reg_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/amba3_apb_reg_slave.sv
// APB3 register-file slave: REG_NUM registers of DATA_SIZE bits with a fixed
// number of wait states before the single-cycle PREADY completion.
module amba3_apb_reg_slave #(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int REG_NUM     = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [ADDR_SIZE-1:0]          paddr,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [DATA_SIZE-1:0]          pwdata,
    output logic                          pready,
    output logic [DATA_SIZE-1:0]          prdata,
    output logic [REG_NUM*DATA_SIZE-1:0]  reg_q,
    output logic [REG_NUM-1:0]            wr_pulse
);

    // Handshake: a transfer starts when psel=1, penable=0 is sampled in IDLE.
    // The slave then holds pready low for WAIT_CYCLES cycles and raises it for
    // exactly one cycle; the master must keep psel high until that cycle ends,
    // otherwise the transfer is dropped without side effects.

    localparam int IDX_W = $clog2(REG_NUM);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [REG_NUM-1:0] ONE_HOT_0 = {{(REG_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t               state;
    logic [3:0]           count;
    logic [IDX_W-1:0]     idx_l;
    logic                 wr_l;
    logic                 hit_l;
    logic [DATA_SIZE-1:0] wdata_l;
    logic [DATA_SIZE-1:0] regs [REG_NUM];

    logic [IDX_W-1:0]     idx_in;
    logic                 hit_in;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_hit;
    logic                 rd_wr;
    logic [DATA_SIZE-1:0] rd_val;

    assign idx_in = paddr[IDX_W+1:2];
    assign hit_in = ((paddr >> (IDX_W + 2)) == '0);

    // With no wait states the read value is captured on the setup edge itself,
    // before the latched copies are valid, so select the live bus in IDLE.
    always_comb begin
        rd_idx = idx_l;
        rd_hit = hit_l;
        rd_wr  = wr_l;
        if (state == S_IDLE) begin
            rd_idx = idx_in;
            rd_hit = hit_in;
            rd_wr  = pwrite;
        end
        rd_val = '0;
        if (!rd_wr && rd_hit) begin
            rd_val = regs[rd_idx];
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= S_IDLE;
            count    <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
            idx_l    <= '0;
            wr_l     <= 1'b0;
            hit_l    <= 1'b0;
            wdata_l  <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pready   <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
            case (state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        idx_l   <= idx_in;
                        wr_l    <= pwrite;
                        hit_l   <= hit_in;
                        wdata_l <= pwdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                            count <= WAIT_INIT;
                        end else begin
                            state  <= S_ACCESS;
                            pready <= 1'b1;
                            prdata <= rd_val;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else if (count == 4'd1) begin
                        state  <= S_ACCESS;
                        count  <= '0;
                        pready <= 1'b1;
                        prdata <= rd_val;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_ACCESS: begin
                    state <= S_IDLE;
                    if (psel && wr_l && hit_l) begin
                        regs[idx_l] <= wdata_l;
                        wr_pulse    <= ONE_HOT_0 << idx_l;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
        assign reg_q[g*DATA_SIZE +: DATA_SIZE] = regs[g];
    end

endmodule
